// File: rtl/lora_uart_tx_arbiter.sv
// Two-requester round-robin arbitrated 8N1 UART transmitter (LSB first)
// driving the LoRa module RXD pin. One byte is latched per grant and
// serialised with a private divide-by-CLK_DIV bit timer.
module lora_uart_tx_arbiter #(
  parameter int unsigned CLK_DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic [7:0] data_a,
  output logic       ack_a,
  input  logic       req_b,
  input  logic [7:0] data_b,
  output logic       ack_b,
  output logic       txd,
  output logic       busy,
  output logic       owner
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  localparam logic [12:0] LP_CNT_LAST = 13'(CLK_DIV - 1);

  state_t      r_state,  w_state_nxt;
  logic [12:0] r_cnt,    w_cnt_nxt;
  logic [2:0]  r_idx,    w_idx_nxt;
  logic [7:0]  r_shift,  w_shift_nxt;
  logic        r_txd,    w_txd_nxt;
  logic        r_ack_a,  w_ack_a_nxt;
  logic        r_ack_b,  w_ack_b_nxt;
  logic        r_busy,   w_busy_nxt;
  logic        r_owner,  w_owner_nxt;
  logic        r_last_b, w_last_b_nxt;

  logic w_bound;
  logic w_grant_a;
  logic w_grant_b;

  // Bit boundary and round-robin grant decode (last grant B favours A)
  always_comb begin
    w_bound   = (r_cnt == LP_CNT_LAST);
    w_grant_a = req_a & (~req_b | r_last_b);
    w_grant_b = req_b & (~req_a | ~r_last_b);
  end

  // State and output registers; reset forces the line idle and drops any frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_shift  <= '0;
      r_txd    <= 1'b1;
      r_ack_a  <= 1'b0;
      r_ack_b  <= 1'b0;
      r_busy   <= 1'b0;
      r_owner  <= 1'b1;
      r_last_b <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_idx    <= w_idx_nxt;
      r_shift  <= w_shift_nxt;
      r_txd    <= w_txd_nxt;
      r_ack_a  <= w_ack_a_nxt;
      r_ack_b  <= w_ack_b_nxt;
      r_busy   <= w_busy_nxt;
      r_owner  <= w_owner_nxt;
      r_last_b <= w_last_b_nxt;
    end
  end

  // Next-state logic; txd is computed one cycle ahead so the line value is
  // registered and changes exactly at the bit boundary
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_idx_nxt    = r_idx;
    w_shift_nxt  = r_shift;
    w_txd_nxt    = r_txd;
    w_ack_a_nxt  = 1'b0;
    w_ack_b_nxt  = 1'b0;
    w_busy_nxt   = r_busy;
    w_owner_nxt  = r_owner;
    w_last_b_nxt = r_last_b;

    case (r_state)
      ST_IDLE: begin
        w_txd_nxt = 1'b1;
        w_cnt_nxt = '0;
        if (w_grant_a || w_grant_b) begin
          w_shift_nxt  = w_grant_a ? data_a : data_b;
          w_ack_a_nxt  = w_grant_a;
          w_ack_b_nxt  = w_grant_b;
          w_owner_nxt  = w_grant_b;
          w_last_b_nxt = w_grant_b;
          w_busy_nxt   = 1'b1;
          w_idx_nxt    = '0;
          w_txd_nxt    = 1'b0;
          w_state_nxt  = ST_START;
        end
      end

      ST_START: begin
        w_cnt_nxt = w_bound ? '0 : r_cnt + 13'd1;
        if (w_bound) begin
          w_idx_nxt   = '0;
          w_txd_nxt   = r_shift[0];
          w_state_nxt = ST_DATA;
        end
      end

      ST_DATA: begin
        w_cnt_nxt = w_bound ? '0 : r_cnt + 13'd1;
        if (w_bound) begin
          if (r_idx == 3'd7) begin
            w_txd_nxt   = 1'b1;
            w_state_nxt = ST_STOP;
          end else begin
            w_shift_nxt = r_shift >> 1;
            w_idx_nxt   = r_idx + 3'd1;
            w_txd_nxt   = r_shift[1];
          end
        end
      end

      ST_STOP: begin
        w_cnt_nxt = w_bound ? '0 : r_cnt + 13'd1;
        w_txd_nxt = 1'b1;
        if (w_bound) begin
          w_busy_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_txd_nxt   = 1'b1;
        w_busy_nxt  = 1'b0;
        w_cnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Registered outputs only; nothing combinational from the request inputs
  always_comb begin
    txd   = r_txd;
    ack_a = r_ack_a;
    ack_b = r_ack_b;
    busy  = r_busy;
    owner = r_owner;
  end

endmodule

// File: tb/tb_lora_uart_tx_arbiter.sv
// Scoreboard bench for lora_uart_tx_arbiter: a transaction-level model
// predicts grants from the request levels, a monitor decodes each frame.
module tb_lora_uart_tx_arbiter;

  localparam int unsigned DIV   = 20;
  localparam int unsigned FRAME = 10 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_a = 1'b0, req_b = 1'b0;
  logic [7:0] data_a = '0, data_b = '0;
  logic       ack_a, ack_b, txd, busy, owner;

  lora_uart_tx_arbiter #(.CLK_DIV(DIV)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .data_a(data_a), .ack_a(ack_a),
    .req_b(req_b), .data_b(data_b), .ack_b(ack_b),
    .txd(txd), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          who;    // 0 = A, 1 = B
    logic [7:0]  byt;
    int unsigned start;  // cycle index of the first START cycle
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc = 0;
  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: the link is free again 10*DIV+1 cycles after a grant;
  // a free link grants the sole requester, or the one not granted last.
  int unsigned m_next_free = 0;
  bit          m_last_b    = 1'b1;
  always @(posedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
      m_next_free = 0;
      m_last_b    = 1'b1;
    end else if (cyc >= m_next_free && (req_a || req_b)) begin
      e.who   = (req_a && req_b) ? !m_last_b : req_b;
      e.byt   = e.who ? data_b : data_a;
      e.start = cyc + 1;
      exp_q.push_back(e);
      m_last_b    = e.who;
      m_next_free = cyc + FRAME + 1;
    end
    cyc++;
  end

  // Monitor state
  bit          rst_seen   = 1'b0;
  bit          m_in_frame = 1'b0;
  bit          exp_owner  = 1'b1;
  exp_t        m_cur;
  int unsigned m_k, bad_txd, bad_ctl, bit_i;
  int unsigned idle_len = 0, idle_bad = 0;
  logic [7:0]  m_rx;
  bit          exp_bit;

  task automatic finalize_idle();
    if (idle_len > 0) check("idle line/busy/owner bad cycles", idle_bad, 0);
    idle_len = 0;
    idle_bad = 0;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (!rst_seen) begin
        rst_seen = 1'b1;
        check("reset {txd,busy,ack_a,ack_b,owner}", {txd, busy, ack_a, ack_b, owner}, 5'b10001);
        m_in_frame = 1'b0;
        exp_owner  = 1'b1;
        idle_len   = 0;
        idle_bad   = 0;
      end
    end else begin
      rst_seen = 1'b0;
      if (!m_in_frame) begin
        if (ack_a || ack_b) begin
          finalize_idle();
          if (exp_q.size() == 0) begin
            check("unexpected ack {ack_a,ack_b}", {ack_a, ack_b}, 0);
          end else begin
            m_cur = exp_q.pop_front();
            check("ack source {ack_a,ack_b}", {ack_a, ack_b}, m_cur.who ? 1 : 2);
            check("frame start cycle", cyc, m_cur.start);
            m_in_frame = 1'b1;
            m_k = 0; bad_txd = 0; bad_ctl = 0; m_rx = '0;
          end
        end else begin
          idle_len++;
          if (txd !== 1'b1 || busy !== 1'b0 || owner !== exp_owner) idle_bad++;
        end
      end
      if (m_in_frame) begin
        bit_i   = m_k / DIV;
        exp_bit = (bit_i == 0) ? 1'b0 : (bit_i == 9) ? 1'b1 : m_cur.byt[bit_i-1];
        if (txd !== exp_bit) bad_txd++;
        if (busy !== 1'b1 || owner !== m_cur.who || (m_k != 0 && (ack_a || ack_b))) bad_ctl++;
        if (m_k % DIV == DIV / 2 && bit_i >= 1 && bit_i <= 8) m_rx[bit_i-1] = txd;
        if (m_k == FRAME - 1) begin
          check("frame byte", m_rx, m_cur.byt);
          check("frame txd bad cycles", bad_txd, 0);
          check("frame busy/owner/ack bad cycles", bad_ctl, 0);
          exp_owner  = m_cur.who;
          m_in_frame = 1'b0;
        end else begin
          m_k++;
        end
      end
    end
  end

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_ack(input bit who, input int unsigned budget, output int unsigned t);
    bit got;
    got = 1'b0;
    t   = 0;
    for (int unsigned i = 0; i < budget && !got; i++) begin
      step(1);
      if (who ? ack_b : ack_a) begin
        got = 1'b1;
        t   = cyc;
      end
    end
    check(who ? "ack_b arrives" : "ack_a arrives", got, 1);
  endtask

  initial begin
    int unsigned t_a, t_b, t0;
    int unsigned ts[$];
    bit          ws[$];

    // Reset, brief activity, reset mid-frame, then long idle
    step(4);
    rst = 1'b0;
    step(2);
    req_a = 1'b1; data_a = 8'h3C;
    wait_ack(1'b0, 10, t0);
    req_a = 1'b0;
    step(3 * DIV);
    rst = 1'b1;
    step(5);
    rst = 1'b0;
    step(10000);

    // Single byte from A
    req_a = 1'b1; data_a = 8'hA5;
    wait_ack(1'b0, 10, t0);
    req_a = 1'b0;
    step(FRAME + 5);

    // Contention straight after reset: A first, then B
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    step(2);
    req_a = 1'b1; data_a = 8'h11;
    req_b = 1'b1; data_b = 8'h22;
    wait_ack(1'b0, 10, t_a);
    req_a = 1'b0;
    wait_ack(1'b1, FRAME + 10, t_b);
    req_b = 1'b0;
    check("contention start spacing", t_b - t_a, FRAME + 1);
    step(FRAME + 5);

    // Fairness with both requests held
    req_a = 1'b1; data_a = 8'($urandom);
    req_b = 1'b1; data_b = 8'($urandom);
    for (int unsigned i = 0; i < 8 * (FRAME + 1) + 50 && ws.size() < 8; i++) begin
      step(1);
      if (ack_a) begin ws.push_back(1'b0); ts.push_back(cyc); data_a = 8'($urandom); end
      if (ack_b) begin ws.push_back(1'b1); ts.push_back(cyc); data_b = 8'($urandom); end
    end
    req_a = 1'b0; req_b = 1'b0;
    check("fairness grant count", ws.size(), 8);
    for (int unsigned i = 1; i < ws.size(); i++) begin
      check("fairness alternation", ws[i] != ws[i-1], 1);
      check("fairness start spacing", ts[i] - ts[i-1], FRAME + 1);
    end
    step(FRAME + 5);

    // B request withdrawn while A's frame is in progress
    req_a = 1'b1; data_a = 8'h96;
    wait_ack(1'b0, 10, t0);
    req_a = 1'b0;
    step(10);
    req_b = 1'b1; data_b = 8'hE7;
    step(100);
    req_b = 1'b0;
    step(FRAME + 20);

    // Reset during DATA bit 3 of 0xFF, then contention resolves to A
    req_a = 1'b1; data_a = 8'hFF;
    wait_ack(1'b0, 10, t0);
    req_a = 1'b0;
    step(4 * DIV + DIV / 2);
    rst = 1'b1;
    req_a = 1'b1; data_a = 8'h5A;
    req_b = 1'b1; data_b = 8'hC3;
    #1;
    check("async reset {txd,busy}", {txd, busy}, 2'b10);
    step(3);
    rst = 1'b0;
    wait_ack(1'b0, 10, t0);
    check("post-reset winner ack_b low", ack_b, 0);
    req_a = 1'b0;
    wait_ack(1'b1, FRAME + 10, t0);
    req_b = 1'b0;
    step(FRAME + 5);

    // Randomised requesters
    for (int unsigned c = 0; c < 12000; c++) begin
      step(1);
      if (req_a && ack_a) begin
        if ($urandom_range(1, 0) == 1) data_a = 8'($urandom);
        else req_a = 1'b0;
      end else if (!req_a && $urandom_range(15, 0) == 0) begin
        req_a = 1'b1; data_a = 8'($urandom);
      end else if (req_a && $urandom_range(199, 0) == 0) begin
        req_a = 1'b0;
      end
      if (req_b && ack_b) begin
        if ($urandom_range(1, 0) == 1) data_b = 8'($urandom);
        else req_b = 1'b0;
      end else if (!req_b && $urandom_range(15, 0) == 0) begin
        req_b = 1'b1; data_b = 8'($urandom);
      end else if (req_b && $urandom_range(199, 0) == 0) begin
        req_b = 1'b0;
      end
    end
    req_a = 1'b0; req_b = 1'b0;
    step(FRAME + 10);

    check("frame in progress at end", m_in_frame, 0);
    check("expected frames left unsent", exp_q.size(), 0);
    finalize_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
